// File: rtl/ctrl_apb_fabric_pkg.sv
// Shared types for the APB request router: FSM states, error causes and
// the slave-index width helper.
package ctrl_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP,
      ST_DRAIN
   } state_t;

   typedef logic [1:0] err_cause_t;

   localparam err_cause_t ERR_NONE    = 2'd0;
   localparam err_cause_t ERR_DECODE  = 2'd1;
   localparam err_cause_t ERR_TIMEOUT = 2'd2;
   localparam err_cause_t ERR_SLAVE   = 2'd3;

   // A single slave still gets a 1-bit index field so the decode stays uniform.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ctrl_apb_fabric_if.sv
// Upstream request bus plus shared downstream bus of the router.
// The slave modport is the router's view; master is the environment's view.
interface ctrl_apb_fabric_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 16,
   parameter int N_SLV  = 4
);
   logic [ADDR_W-1:0]       req_paddr;
   logic                    req_pwrite;
   logic                    req_psel;
   logic                    req_penable;
   logic [DATA_W-1:0]       req_pwdata;
   logic                    req_pready;
   logic [DATA_W-1:0]       req_prdata;
   logic                    req_pslverr;

   logic [ADDR_W-1:0]       m_paddr;
   logic                    m_pwrite;
   logic [DATA_W-1:0]       m_pwdata;
   logic                    m_penable;
   logic [N_SLV-1:0]        m_psel;
   logic [N_SLV-1:0]        m_pready;
   logic [N_SLV*DATA_W-1:0] m_prdata;
   logic [N_SLV-1:0]        m_pslverr;

   modport slave (
      input  req_paddr, req_pwrite, req_psel, req_penable, req_pwdata,
      output req_pready, req_prdata, req_pslverr,
      output m_paddr, m_pwrite, m_pwdata, m_penable, m_psel,
      input  m_pready, m_prdata, m_pslverr
   );

   modport master (
      output req_paddr, req_pwrite, req_psel, req_penable, req_pwdata,
      input  req_pready, req_prdata, req_pslverr,
      input  m_paddr, m_pwrite, m_pwdata, m_penable, m_psel,
      output m_pready, m_prdata, m_pslverr
   );
endinterface

// File: rtl/ctrl_apb_wdog.sv
// Access watchdog: cleared before each ACCESS phase, counts stalled cycles,
// saturates at TIMEOUT so a disabled watchdog never wraps.
module ctrl_apb_wdog #(
   parameter int TIMEOUT = 255,
   localparam int CW     = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && cnt != CW'(TIMEOUT))
         cnt <= cnt + 1'b1;
   end

   // Fires on the TIMEOUT-th stalled cycle; >= covers a late enable.
   assign expire = (cnt >= CW'(TIMEOUT - 1));
endmodule

// File: rtl/ctrl_apb_fabric.sv
// APB router: decodes the upstream address to one of N_SLV slaves, runs a
// SETUP/ACCESS cycle, and converts decode misses and stalls into PSLVERR.
module ctrl_apb_fabric
   import ctrl_apb_pkg::*;
#(
   parameter int ADDR_W  = 21,
   parameter int DATA_W  = 16,
   parameter int N_SLV   = 4,
   parameter int SEL_LSB = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   ctrl_apb_fabric_if.slave bus,
   input  logic             watchdog_enable,
   output logic             err_pulse,
   output logic [7:0]       err_cnt,
   input  logic             err_cnt_clr
);
   localparam int SEL_W = sel_w(N_SLV);
   localparam logic [SEL_W:0] N_SLV_V = (SEL_W + 1)'(N_SLV);

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  idx_q, idx_in;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q, prdata_q, sel_rdata;
   err_cause_t        cause_q;
   logic              abort_q, abort_now;
   logic              upper_zero, mapped, latch;
   logic              sel_ready, sel_err, wd_clr, wd_en, wd_expire, timeout;

   assign idx_in = bus.req_paddr[SEL_LSB +: SEL_W];

   if (SEL_LSB + SEL_W < ADDR_W) begin : g_upper
      assign upper_zero = ~|bus.req_paddr[ADDR_W-1:SEL_LSB+SEL_W];
   end else begin : g_no_upper
      assign upper_zero = 1'b1;
   end

   assign mapped    = upper_zero && ({1'b0, idx_in} < N_SLV_V);
   assign sel_ready = bus.m_pready[idx_q];
   assign sel_err   = bus.m_pslverr[idx_q];
   assign sel_rdata = bus.m_prdata[idx_q*DATA_W +: DATA_W];

   assign wd_clr  = (state == ST_SETUP);
   assign wd_en   = (state == ST_ACCESS) && !sel_ready;
   assign timeout = watchdog_enable && wd_expire && !sel_ready;
   // An upstream drop seen in the completing cycle counts as an abort too.
   assign abort_now = abort_q || !bus.req_psel;

   ctrl_apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .en     (wd_en),
      .expire (wd_expire)
   );

   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      case (state)
         ST_IDLE:
            if (bus.req_psel && !bus.req_penable) begin
               latch     = 1'b1;
               state_nxt = mapped ? ST_SETUP : ST_RESP;
            end
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS:
            if (sel_ready || timeout)
               state_nxt = abort_now ? ST_DRAIN : ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         ST_DRAIN:  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx_q    <= '0;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         prdata_q <= '0;
         cause_q  <= ERR_NONE;
         abort_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (latch) begin
            idx_q    <= idx_in;
            paddr_q  <= bus.req_paddr;
            pwrite_q <= bus.req_pwrite;
            pwdata_q <= bus.req_pwdata;
            abort_q  <= 1'b0;
            if (!mapped) begin
               prdata_q <= '0;
               cause_q  <= ERR_DECODE;
            end
         end
         if (state == ST_SETUP || state == ST_ACCESS)
            abort_q <= abort_now;
         // Drained completions leave the last delivered response untouched.
         if (state == ST_ACCESS && state_nxt == ST_RESP) begin
            if (sel_ready) begin
               prdata_q <= sel_rdata;
               cause_q  <= sel_err ? ERR_SLAVE : ERR_NONE;
            end else begin
               prdata_q <= '0;
               cause_q  <= ERR_TIMEOUT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || err_cnt_clr)
         err_cnt <= '0;
      else if (err_pulse && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end

   for (genvar i = 0; i < N_SLV; i++) begin : g_psel
      assign bus.m_psel[i] = (state == ST_SETUP || state == ST_ACCESS) &&
                             (idx_q == SEL_W'(i));
   end

   assign bus.m_penable   = (state == ST_ACCESS);
   assign bus.m_paddr     = paddr_q;
   assign bus.m_pwrite    = pwrite_q;
   assign bus.m_pwdata    = pwdata_q;
   assign bus.req_pready  = (state == ST_RESP);
   assign bus.req_prdata  = prdata_q;
   assign bus.req_pslverr = (cause_q != ERR_NONE);
   assign err_pulse       = (state == ST_RESP) && (cause_q != ERR_NONE);
endmodule
